// File: rtl/pio_cc_arbiter.sv
`default_nettype none

`ifndef PIO_DATA_W
`define PIO_DATA_W 256
`endif

// ============================================================================
//  Module      : pio_cc_arbiter
//  Description : Packet-level round-robin arbiter that merges the completion
//                streams of the PIO BAR handlers onto the single PCIe CC AXIS
//                port. A granted channel owns the port from its first beat to
//                tlast. One output register stage isolates cc_tready from the
//                source readies.
//  Revision    : 1.0 - initial release
// ============================================================================
module pio_cc_arbiter #(
  parameter int CHNL_NUM = 4,
  parameter int DATA_W   = `PIO_DATA_W,
  parameter int KEEP_W   = 8,
  parameter int USER_W   = 33
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [CHNL_NUM-1:0]          s_axis_cpl_tvalid,
  input  logic [CHNL_NUM-1:0]          s_axis_cpl_tlast,
  input  logic [CHNL_NUM*DATA_W-1:0]   s_axis_cpl_tdata,
  input  logic [CHNL_NUM*KEEP_W-1:0]   s_axis_cpl_tkeep,
  input  logic [CHNL_NUM*USER_W-1:0]   s_axis_cpl_tuser,
  output logic [CHNL_NUM-1:0]          s_axis_cpl_tready,
  output logic                         cc_tvalid,
  output logic                         cc_tlast,
  output logic [DATA_W-1:0]            cc_tdata,
  output logic [KEEP_W-1:0]            cc_tkeep,
  output logic [USER_W-1:0]            cc_tuser,
  input  logic                         cc_tready,
  output logic [15:0]                  cpl_pkt_cnt,
  output logic [2:0]                   cur_grant
);

  // One-hot state encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'b01,
    ST_BUSY = 2'b10
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          grant_q, grant_d;
  logic [2:0]          last_grant_q, last_grant_d;

  logic                cc_tvalid_q;
  logic                cc_tlast_q;
  logic [DATA_W-1:0]   cc_tdata_q;
  logic [KEEP_W-1:0]   cc_tkeep_q;
  logic [USER_W-1:0]   cc_tuser_q;
  logic [15:0]         cnt_q;

  logic                sel_valid;
  logic                sel_last;
  logic [DATA_W-1:0]   sel_data;
  logic [KEEP_W-1:0]   sel_keep;
  logic [USER_W-1:0]   sel_user;

  logic                out_free;
  logic                accept;
  logic                found;
  logic [2:0]          winner;
  int                  idx;

  // Output register can take a beat when empty or draining this cycle
  assign out_free = !cc_tvalid_q | cc_tready;
  assign accept   = (state_q == ST_BUSY) & sel_valid & out_free;

  // Mux the granted channel's stream; out-of-range grants select nothing
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    sel_keep  = '0;
    sel_user  = '0;
    for (int i = 0; i < CHNL_NUM; i++) begin
      if (grant_q == 3'(i)) begin
        sel_valid = s_axis_cpl_tvalid[i];
        sel_last  = s_axis_cpl_tlast[i];
        sel_data  = s_axis_cpl_tdata[i*DATA_W +: DATA_W];
        sel_keep  = s_axis_cpl_tkeep[i*KEEP_W +: KEEP_W];
        sel_user  = s_axis_cpl_tuser[i*USER_W +: USER_W];
      end
    end
  end

  // Only the granted channel sees ready, and only while BUSY; ready never
  // depends on that channel's own tvalid
  always_comb begin
    s_axis_cpl_tready = '0;
    if (state_q == ST_BUSY) begin
      for (int i = 0; i < CHNL_NUM; i++) begin
        if (grant_q == 3'(i)) begin
          s_axis_cpl_tready[i] = out_free;
        end
      end
    end
  end

  // Round-robin search starting just after the last completed grant
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 1; k <= CHNL_NUM; k++) begin
      idx = int'(last_grant_q) + k;
      if (idx >= CHNL_NUM) begin
        idx = idx - CHNL_NUM;
      end
      for (int i = 0; i < CHNL_NUM; i++) begin
        if (!found && (i == idx) && s_axis_cpl_tvalid[i]) begin
          found  = 1'b1;
          winner = 3'(i);
        end
      end
    end
  end

  // Next-state: grant in IDLE, hold the lock in BUSY until tlast is taken
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          grant_d = winner;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (accept && sel_last) begin
          last_grant_d = grant_q;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and grant registers; last_grant resets so channel 0 wins first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= 3'(CHNL_NUM - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Output stage: load accepted beats, drop valid once consumed, else hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_tvalid_q <= 1'b0;
      cc_tlast_q  <= 1'b0;
      cc_tdata_q  <= '0;
      cc_tkeep_q  <= '0;
      cc_tuser_q  <= '0;
    end else if (accept) begin
      cc_tvalid_q <= 1'b1;
      cc_tlast_q  <= sel_last;
      cc_tdata_q  <= sel_data;
      cc_tkeep_q  <= sel_keep;
      cc_tuser_q  <= sel_user;
    end else if (cc_tready) begin
      cc_tvalid_q <= 1'b0;
    end
  end

  // Count packets whose last beat has been taken by the PCIe core
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (cc_tvalid_q && cc_tready && cc_tlast_q) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign cc_tvalid   = cc_tvalid_q;
  assign cc_tlast    = cc_tlast_q;
  assign cc_tdata    = cc_tdata_q;
  assign cc_tkeep    = cc_tkeep_q;
  assign cc_tuser    = cc_tuser_q;
  assign cpl_pkt_cnt = cnt_q;
  assign cur_grant   = grant_q;

endmodule

`default_nettype wire

// File: tb/tb_pio_cc_arbiter.sv
`default_nettype none

// ============================================================================
//  Module      : tb_pio_cc_arbiter
//  Description : Directed self-checking bench for pio_cc_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pio_cc_arbiter;

  localparam int N  = 4;
  localparam int DW = 256;
  localparam int KW = 8;
  localparam int UW = 33;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    s_tvalid, s_tlast, s_tready;
  logic [N*DW-1:0] s_tdata;
  logic [N*KW-1:0] s_tkeep;
  logic [N*UW-1:0] s_tuser;
  logic            cc_tvalid, cc_tlast, cc_tready;
  logic [DW-1:0]   cc_tdata;
  logic [KW-1:0]   cc_tkeep;
  logic [UW-1:0]   cc_tuser;
  logic [15:0]     cnt;
  logic [2:0]      cur_grant;

  always #5 clk = ~clk;

  pio_cc_arbiter #(.CHNL_NUM(N), .DATA_W(DW), .KEEP_W(KW), .USER_W(UW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .s_axis_cpl_tvalid (s_tvalid),
    .s_axis_cpl_tlast  (s_tlast),
    .s_axis_cpl_tdata  (s_tdata),
    .s_axis_cpl_tkeep  (s_tkeep),
    .s_axis_cpl_tuser  (s_tuser),
    .s_axis_cpl_tready (s_tready),
    .cc_tvalid         (cc_tvalid),
    .cc_tlast          (cc_tlast),
    .cc_tdata          (cc_tdata),
    .cc_tkeep          (cc_tkeep),
    .cc_tuser          (cc_tuser),
    .cc_tready         (cc_tready),
    .cpl_pkt_cnt       (cnt),
    .cur_grant         (cur_grant)
  );

  int n_pass  = 0;
  int n_total = 0;
  int cyc;

  // Per-channel packet sources
  int len  [N];
  int rem  [N];
  int beat [N];
  int pkt  [N];
  bit gap  [N];

  // Log of beats handed to CC
  logic [DW-1:0] log_data [64];
  logic          log_last [64];
  logic [KW-1:0] log_keep [64];
  logic [UW-1:0] log_user [64];
  int            log_cyc  [64];
  int            log_n;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [DW-1:0] beat_word(input int c, input int p, input int b);
    return DW'({8'(c), 8'(p), 8'(b)});
  endfunction

  task automatic drive();
    for (int c = 0; c < N; c++) begin
      s_tvalid[c]          = (rem[c] > 0) && !gap[c];
      s_tlast[c]           = (beat[c] == len[c] - 1);
      s_tdata[c*DW +: DW]  = beat_word(c, pkt[c], beat[c]);
      s_tkeep[c*KW +: KW]  = 8'hFF >> beat[c];
      s_tuser[c*UW +: UW]  = {1'b1, 32'(c*16 + beat[c])};
    end
  endtask

  // One clock cycle: sample handshakes before the edge, advance sources after
  task automatic step();
    logic [N-1:0] acc;
    #1;
    acc = s_tvalid & s_tready;
    if (cc_tvalid && cc_tready && log_n < 64) begin
      log_data[log_n] = cc_tdata;
      log_last[log_n] = cc_tlast;
      log_keep[log_n] = cc_tkeep;
      log_user[log_n] = cc_tuser;
      log_cyc[log_n]  = cyc;
      log_n++;
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int c = 0; c < N; c++) begin
      if (acc[c]) begin
        if (beat[c] == len[c] - 1) begin
          beat[c] = 0;
          pkt[c]++;
          rem[c]--;
        end else begin
          beat[c]++;
        end
      end
    end
    drive();
  endtask

  task automatic clear_src();
    for (int c = 0; c < N; c++) begin
      len[c]  = 1;
      rem[c]  = 0;
      beat[c] = 0;
      pkt[c]  = 0;
      gap[c]  = 1'b0;
    end
    log_n = 0;
    cyc   = 0;
    drive();
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    cc_tready = 1'b1;
    clear_src();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---------------- reset state and single source ch2 ----------------
    do_reset();
    chk("rst_tvalid", cc_tvalid, 0);
    chk("rst_tlast",  cc_tlast,  0);
    chk("rst_tdata",  cc_tdata,  0);
    chk("rst_tkeep",  cc_tkeep,  0);
    chk("rst_tuser",  cc_tuser,  0);
    chk("rst_tready", s_tready,  0);
    chk("rst_cnt",    cnt,       0);
    chk("rst_grant",  cur_grant, 0);

    len[2] = 3; rem[2] = 1; drive();
    repeat (6) step();
    chk("single_n", log_n, 3);
    for (int b = 0; b < 3; b++) begin
      chk("single_data", log_data[b], beat_word(2, 0, b));
      chk("single_cyc",  log_cyc[b],  2 + b);
      chk("single_last", log_last[b], (b == 2));
    end
    chk("single_keep", log_keep[2], 8'h3F);
    chk("single_user", log_user[2], {1'b1, 32'h22});
    chk("single_cnt",  cnt,       1);
    chk("single_grnt", cur_grant, 2);

    // ---------------- simultaneous ch0/ch1 after reset ----------------
    do_reset();
    len[0] = 1; rem[0] = 1; len[1] = 1; rem[1] = 1; drive();
    repeat (7) step();
    chk("simul_n",     log_n, 2);
    chk("simul_data0", log_data[0], beat_word(0, 0, 0));
    chk("simul_cyc0",  log_cyc[0], 2);
    chk("simul_data1", log_data[1], beat_word(1, 0, 0));
    chk("simul_cyc1",  log_cyc[1], 4);

    // ---------------- fairness: 4 channels, 16 two-beat packets ----------------
    do_reset();
    for (int c = 0; c < N; c++) begin
      len[c] = 2; rem[c] = 4;
    end
    drive();
    repeat (52) step();
    chk("fair_n", log_n, 32);
    for (int k = 0; k < 16; k++) begin
      chk("fair_order", log_data[2*k], beat_word(k % 4, k / 4, 0));
    end
    chk("fair_cyc15", log_cyc[30], 47);
    chk("fair_cnt",   cnt, 16);

    // ---------------- backpressure mid-packet ----------------
    do_reset();
    len[0] = 4; rem[0] = 1; drive();
    repeat (3) step();
    cc_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_tready", s_tready, 0);
      chk("bp_tvalid", cc_tvalid, 1);
      chk("bp_tdata",  cc_tdata, beat_word(0, 0, 1));
      step();
    end
    cc_tready = 1'b1;
    repeat (6) step();
    chk("bp_n", log_n, 4);
    for (int b = 0; b < 4; b++) begin
      chk("bp_data", log_data[b], beat_word(0, 0, b));
      chk("bp_last", log_last[b], (b == 3));
    end
    chk("bp_cnt", cnt, 1);

    // ---------------- lock hold across a valid gap ----------------
    do_reset();
    len[1] = 4; rem[1] = 1; len[3] = 1; rem[3] = 1; drive();
    for (int t = 0; t < 10 && beat[1] < 2; t++) step();
    chk("lock_reach", beat[1], 2);
    gap[1] = 1'b1; drive();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("lock_rdy", s_tready, 4'b0010);
      step();
    end
    gap[1] = 1'b0; drive();
    repeat (10) step();
    chk("lock_n",     log_n, 5);
    chk("lock_b3",    log_data[3], beat_word(1, 0, 3));
    chk("lock_last3", log_last[3], 1);
    chk("lock_ch3",   log_data[4], beat_word(3, 0, 0));

    // ---------------- reset mid-packet ----------------
    do_reset();
    len[0] = 4; rem[0] = 1; drive();
    for (int t = 0; t < 10 && beat[0] < 2; t++) step();
    chk("mrst_reach", beat[0], 2);
    rst_n = 1'b0;
    #1;
    chk("mrst_tready", s_tready,  0);
    chk("mrst_tvalid", cc_tvalid, 0);
    chk("mrst_tlast",  cc_tlast,  0);
    chk("mrst_tdata",  cc_tdata,  0);
    chk("mrst_tkeep",  cc_tkeep,  0);
    chk("mrst_tuser",  cc_tuser,  0);
    chk("mrst_cnt",    cnt,       0);
    chk("mrst_grant",  cur_grant, 0);
    do_reset();
    len[0] = 2; rem[0] = 1; drive();
    repeat (6) step();
    chk("mrst_n",     log_n, 2);
    chk("mrst_data0", log_data[0], beat_word(0, 0, 0));
    chk("mrst_data1", log_data[1], beat_word(0, 0, 1));
    chk("mrst_cnt2",  cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pio_cc_arbiter.md
# pio_cc_arbiter

Packet-level round-robin arbiter that merges completion streams from up to `CHNL_NUM` PIO BAR handlers onto the single PCIe Completer Completion (CC) AXIS interface. It sits downstream of the per-BAR PIO handlers, which consume requests from the CQ parser and return read completions carrying the 96-bit CC descriptor header. A channel keeps the CC port from its first beat to `tlast`, so packets are never interleaved. A single output register stage decouples the CC `tready` from the source `tready`s.

## Interface
- `CHNL_NUM`, 4: number of completion sources, 2..8.
- `DATA_W`, `` `PIO_DATA_W `` (256): beat width.
- `KEEP_W`, 8: dword keep width (`DATA_W/32`).
- `USER_W`, 33: CC `tuser` width.
- `clk` input 1: clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `s_axis_cpl_tvalid` input `CHNL_NUM`: per-source valid.
- `s_axis_cpl_tlast` input `CHNL_NUM`: per-source last.
- `s_axis_cpl_tdata` input `CHNL_NUM*DATA_W`: source i occupies bits [i*DATA_W +: DATA_W].
- `s_axis_cpl_tkeep` input `CHNL_NUM*KEEP_W`: packed the same way as `tdata`.
- `s_axis_cpl_tuser` input `CHNL_NUM*USER_W`: packed the same way as `tdata`.
- `s_axis_cpl_tready` output `CHNL_NUM`: per-source ready, one-hot or zero.
- `cc_tvalid` output 1: CC valid.
- `cc_tlast` output 1: CC last.
- `cc_tdata` output `DATA_W`: CC data.
- `cc_tkeep` output `KEEP_W`: CC keep.
- `cc_tuser` output `USER_W`: CC user.
- `cc_tready` input 1: CC ready from the PCIe core.
- `cpl_pkt_cnt` output 16: count of completion packets fully handed to CC. It wraps modulo 2^16.
- `cur_grant` output 3: index of the current or last granted channel, for debug.

## Operation
- **State machine:** two states, IDLE and BUSY. The state is one-hot encoded with a default to IDLE.
- **IDLE:**
  - No source `tready` is asserted.
  - If any `s_axis_cpl_tvalid` is set, the winner is the first requesting index found searching `last_grant+1, last_grant+2, …` with wraparound modulo `CHNL_NUM`.
  - On a win, `grant <= winner` and the state moves to BUSY next cycle.
  - With no requests, the state stays IDLE.
- **BUSY:**
  - `s_axis_cpl_tready[grant] = out_free`, where `out_free = !cc_tvalid | cc_tready`. All other readies are 0.
  - A beat is accepted when `s_axis_cpl_tvalid[grant] & s_axis_cpl_tready[grant]`. The accepted beat's data, keep, user and last are loaded into the output register, and `cc_tvalid <= 1`.
  - An accepted beat with `tlast=1` causes `last_grant <= grant` and a return to IDLE.
  - The grant is locked until `tlast`. Gaps in valid from the granted source hold the lock indefinitely. Other requesters wait.
- **Output register:**
  - When `cc_tready=1` and no new beat is loaded, `cc_tvalid <= 0`.
  - While `cc_tvalid & !cc_tready`, the contents are held stable. AXIS rules apply: data never changes while valid and not ready.
- **Packet counter:** `cpl_pkt_cnt` increments when `cc_tvalid & cc_tready & cc_tlast`.
- **`tkeep`/`tuser`:** forwarded unmodified. The arbiter never inspects headers.
- **Channel range:** indices at or above `CHNL_NUM` never win.

## Timing
- **Reset values:**
  - State IDLE, `grant = 0`, `last_grant = CHNL_NUM-1`, so channel 0 has first priority.
  - `s_axis_cpl_tready = 0`.
  - `cc_tvalid = 0`, `cc_tlast = 0`, `cc_tdata = 0`, `cc_tkeep = 0`, `cc_tuser = 0`.
  - `cpl_pkt_cnt = 0`, `cur_grant = 0`.
- **Latency:**
  - Request to grant: 1 cycle (the IDLE cycle).
  - First beat accepted: the first BUSY cycle.
  - First beat on CC: the cycle after acceptance.
  - Source valid at cycle 0 in IDLE gives `cc_tvalid` at cycle 2.
- **Throughput:** 1 beat/cycle within a packet while `cc_tready=1`. There is exactly one IDLE bubble cycle between consecutive packets.
- **Ready dependency:** `s_axis_cpl_tready` depends combinationally on `cc_tready`. No combinational path exists from any source `tvalid` to its own `tready`.
- **Reset mid-packet:** all state and outputs return to reset values immediately. Partial packets are not resumed, and sources must be reset together with the arbiter.
- **Simultaneous tlast and new request:** the state returns to IDLE, and arbitration in the next cycle uses the updated `last_grant`.

## Test plan
- **Single source:** ch2 sends a 3-beat packet with `cc_tready=1`.
  - `cc_tvalid` is high for cycles 2–4 with data in order and `tlast` on beat 3.
  - `cpl_pkt_cnt=1`, `cur_grant=2`.
- **Simultaneous requests after reset:** ch0 and ch1 each send a 1-beat packet at cycle 0.
  - ch0 is forwarded first and ch1 second, with one bubble cycle between them.
- **Fairness:** all 4 channels request continuously with 2-beat packets for 16 packets.
  - Grant order is 0,1,2,3,0,…; each channel gets exactly 4 packets; `cpl_pkt_cnt=16`.
- **Backpressure:** hold `cc_tready=0` for 5 cycles mid-packet.
  - `cc_tdata` stays stable and `s_axis_cpl_tready[grant]=0` throughout.
  - No beat is lost or duplicated after release.
- **Lock hold:** ch1's valid drops for 4 cycles mid-packet while ch3 requests.
  - ch3's ready stays 0 until ch1's `tlast` is accepted.
- **Reset mid-packet:** assert `rst_n=0` during beat 2 of 4.
  - All outputs are at reset values the same cycle.
  - After release, a new ch0 packet is forwarded normally.
